// File: rtl/alu_response_checker.sv
// Golden-model checker for the 4-bit ALU: predicts each response, delay-matches it to the ALU
// latency, compares against the observed outputs, and tracks error statistics and a sticky alarm.
module alu_response_checker #(
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned ALARM_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [1:0]       in_op,
    input  logic [3:0]       dut_result,
    input  logic             dut_carry,
    input  logic             dut_zero,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [3:0]       exp_result,
    output logic             exp_carry,
    output logic             exp_zero,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count,
    output logic             alarm,
    output logic [9:0]       first_err_info
);

    typedef struct packed {
        logic       vld;
        logic [3:0] res;
        logic       carry;
        logic       zero;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StRun, StAlarm} state_e;

    localparam logic [CNT_W-1:0] ThreshC = CNT_W'(ALARM_THRESH);

    entry_t [LATENCY-1:0] pipe_q, pipe_d;
    entry_t               new_e, tail;
    logic   [4:0]         sum, diff;
    logic                 obs_mm;

    state_e               state_q, state_d;
    logic                 chk_valid_q, chk_valid_d;
    logic                 mismatch_q, mismatch_d;
    logic   [3:0]         exp_result_q, exp_result_d;
    logic                 exp_carry_q, exp_carry_d;
    logic                 exp_zero_q, exp_zero_d;
    logic   [CNT_W-1:0]   txn_count_q, txn_count_d;
    logic   [CNT_W-1:0]   err_count_q, err_count_d;
    logic                 captured_q, captured_d;
    logic   [9:0]         first_err_q, first_err_d;

    // Expected response, computed with a 5-bit datapath so carry/borrow fall out of bit 4.
    always_comb begin
        sum       = {1'b0, in_a} + {1'b0, in_b};
        diff      = {1'b0, in_a} - {1'b0, in_b};
        new_e     = '0;
        new_e.vld = in_valid;
        new_e.op  = in_op;
        new_e.a   = in_a;
        new_e.b   = in_b;
        unique case (in_op)
            2'b00: {new_e.carry, new_e.res} = sum;
            2'b01: {new_e.carry, new_e.res} = diff;
            2'b10: new_e.res = in_a & in_b;
            2'b11: new_e.res = in_a | in_b;
            default: new_e.res = 4'd0;
        endcase
        new_e.zero = (new_e.res == 4'd0);
    end

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = new_e;
        for (int i = 1; i < int'(LATENCY); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        if (clear) begin
            pipe_d = '0;
        end
    end

    assign tail   = pipe_q[LATENCY-1];
    assign obs_mm = {tail.res, tail.carry, tail.zero} != {dut_result, dut_carry, dut_zero};

    always_comb begin
        state_d      = state_q;
        chk_valid_d  = 1'b0;
        mismatch_d   = mismatch_q;
        exp_result_d = exp_result_q;
        exp_carry_d  = exp_carry_q;
        exp_zero_d   = exp_zero_q;
        txn_count_d  = txn_count_q;
        err_count_d  = err_count_q;
        captured_d   = captured_q;
        first_err_d  = first_err_q;
        if (tail.vld) begin
            chk_valid_d  = 1'b1;
            mismatch_d   = obs_mm;
            exp_result_d = tail.res;
            exp_carry_d  = tail.carry;
            exp_zero_d   = tail.zero;
            txn_count_d  = txn_count_q + CNT_W'(1);
            if (obs_mm) begin
                if (err_count_q != {CNT_W{1'b1}}) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
                if (!captured_q) begin
                    captured_d  = 1'b1;
                    first_err_d = {tail.op, tail.a, tail.b};
                end
            end
            unique case (state_q)
                StIdle, StRun: state_d = (err_count_d >= ThreshC) ? StAlarm : StRun;
                StAlarm:       state_d = StAlarm;
                default:       state_d = StIdle;
            endcase
        end
        if (clear) begin
            state_d      = StIdle;
            chk_valid_d  = 1'b0;
            mismatch_d   = 1'b0;
            exp_result_d = 4'd0;
            exp_carry_d  = 1'b0;
            exp_zero_d   = 1'b0;
            txn_count_d  = '0;
            err_count_d  = '0;
            captured_d   = 1'b0;
            first_err_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q       <= '0;
            state_q      <= StIdle;
            chk_valid_q  <= 1'b0;
            mismatch_q   <= 1'b0;
            exp_result_q <= 4'd0;
            exp_carry_q  <= 1'b0;
            exp_zero_q   <= 1'b0;
            txn_count_q  <= '0;
            err_count_q  <= '0;
            captured_q   <= 1'b0;
            first_err_q  <= '0;
        end else begin
            pipe_q       <= pipe_d;
            state_q      <= state_d;
            chk_valid_q  <= chk_valid_d;
            mismatch_q   <= mismatch_d;
            exp_result_q <= exp_result_d;
            exp_carry_q  <= exp_carry_d;
            exp_zero_q   <= exp_zero_d;
            txn_count_q  <= txn_count_d;
            err_count_q  <= err_count_d;
            captured_q   <= captured_d;
            first_err_q  <= first_err_d;
        end
    end

    assign chk_valid      = chk_valid_q;
    assign mismatch       = mismatch_q;
    assign exp_result     = exp_result_q;
    assign exp_carry      = exp_carry_q;
    assign exp_zero       = exp_zero_q;
    assign txn_count      = txn_count_q;
    assign err_count      = err_count_q;
    assign alarm          = (state_q == StAlarm);
    assign first_err_info = first_err_q;

endmodule

// File: tb/tb_alu_response_checker.sv
// Scoreboard bench: the bench plays the ALU (correct or corrupted responses), queues the
// expected checker response at issue time, and a negedge monitor pops and compares.
module tb_alu_response_checker;

    localparam int L  = 2;
    localparam int W  = 4;
    localparam int TH = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic [3:0]   in_a = '0;
    logic [3:0]   in_b = '0;
    logic [1:0]   in_op = '0;
    logic [3:0]   dut_result = '0;
    logic         dut_carry = 1'b0;
    logic         dut_zero = 1'b0;
    logic         chk_valid, mismatch, exp_carry, exp_zero, alarm;
    logic [3:0]   exp_result;
    logic [W-1:0] txn_count, err_count;
    logic [9:0]   first_err_info;

    alu_response_checker #(
        .LATENCY     (L),
        .CNT_W       (W),
        .ALARM_THRESH(TH)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_op         (in_op),
        .dut_result    (dut_result),
        .dut_carry     (dut_carry),
        .dut_zero      (dut_zero),
        .chk_valid     (chk_valid),
        .mismatch      (mismatch),
        .exp_result    (exp_result),
        .exp_carry     (exp_carry),
        .exp_zero      (exp_zero),
        .txn_count     (txn_count),
        .err_count     (err_count),
        .alarm         (alarm),
        .first_err_info(first_err_info)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int issue;
        int op, a, b;
        int res, cy, zf;
        bit mm;
    } exp_t;

    exp_t sbq[$];
    int   sched[int];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Returns {result, carry, zero} packed as result*4 + carry*2 + zero.
    function automatic int model(input int op, input int a, input int b);
        int r, c;
        c = 0;
        case (op)
            0: begin r = a + b; c = (r > 15) ? 1 : 0; r = r % 16; end
            1: begin c = (a < b) ? 1 : 0; r = (a - b + 16) % 16; end
            2: r = a & b;
            default: r = a | b;
        endcase
        return r * 4 + c * 2 + ((r == 0) ? 1 : 0);
    endfunction

    task automatic cycle(input bit v, input int a, input int b, input int op,
                         input bit bad, input bit clr);
        exp_t e;
        int   m, drv;
        @(posedge clk);
        #1;
        clear    = clr;
        in_valid = v;
        in_a     = 4'(a);
        in_b     = 4'(b);
        in_op    = 2'(op);
        if (sched.exists(cyc)) begin
            {dut_result, dut_carry, dut_zero} = 6'(sched[cyc]);
            sched.delete(cyc);
        end else begin
            {dut_result, dut_carry, dut_zero} = 6'($urandom);
        end
        if (v) begin
            m   = model(op, a, b);
            drv = bad ? (m ^ int'($urandom_range(1, 63))) : m;
            sched[cyc + L] = drv;
            e.issue = cyc;
            e.op = op; e.a = a; e.b = b;
            e.res = m / 4; e.cy = (m / 2) % 2; e.zf = m % 2;
            e.mm = (drv != m);
            sbq.push_back(e);
        end
    endtask

    // Reference state
    bit   mon_en = 1'b0;
    int   m_txn = 0, m_err = 0, m_first = 0;
    bit   m_alarm = 1'b0, m_capt = 1'b0;
    int   h_res = 0, h_cy = 0, h_zf = 0, h_mm = 0;
    bit   held_known = 1'b1;
    bit   expv;
    exp_t pe;

    always @(negedge clk) begin
        if (mon_en) begin
            while (sbq.size() > 0 && sbq[0].issue + L + 1 < cyc) begin
                chk("missed_chk_valid", 0, 1);
                void'(sbq.pop_front());
            end
            expv = (sbq.size() > 0) && (sbq[0].issue + L + 1 == cyc);
            chk("chk_valid", int'(chk_valid), int'(expv));
            if (expv) begin
                pe = sbq.pop_front();
                h_res = pe.res; h_cy = pe.cy; h_zf = pe.zf; h_mm = int'(pe.mm);
                held_known = 1'b1;
                m_txn = (m_txn + 1) % (1 << W);
                if (pe.mm) begin
                    if (m_err < (1 << W) - 1) m_err++;
                    if (!m_capt) begin
                        m_capt  = 1'b1;
                        m_first = pe.op * 256 + pe.a * 16 + pe.b;
                    end
                end
                if (m_err >= TH) m_alarm = 1'b1;
            end
            if (held_known) begin
                chk("mismatch", int'(mismatch), h_mm);
                chk("exp_result", int'(exp_result), h_res);
                chk("exp_carry", int'(exp_carry), h_cy);
                chk("exp_zero", int'(exp_zero), h_zf);
            end
            chk("txn_count", int'(txn_count), m_txn);
            chk("err_count", int'(err_count), m_err);
            chk("alarm", int'(alarm), int'(m_alarm));
            chk("first_err_info", int'(first_err_info), m_first);
            if (rst || clear) begin
                m_txn = 0; m_err = 0; m_first = 0; m_alarm = 1'b0; m_capt = 1'b0;
                held_known = rst;
                h_res = 0; h_cy = 0; h_zf = 0; h_mm = 0;
                while (sbq.size() > 0 && sbq[$].issue >= cyc - L) void'(sbq.pop_back());
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) cycle(0, 0, 0, 0, 0, 0);

        // Single good ADD, then erroneous SUB and a second bad transaction
        cycle(1, 7, 9, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 3, 5, 1, 1, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 12, 6, 2, 1, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);

        // Back-to-back burst, only the AND is corrupted; third error trips the alarm
        cycle(1, 1, 1, 0, 0, 0);
        cycle(1, 0, 0, 3, 0, 0);
        cycle(1, 15, 10, 2, 1, 0);
        cycle(1, 9, 9, 1, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 0, 0);

        // Clear with a transaction in flight, plus an in_valid in the clear cycle itself
        cycle(1, 4, 4, 0, 1, 0);
        cycle(1, 2, 3, 0, 0, 1);
        repeat (4) cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 8, 8, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 0, 0);

        // Random traffic with occasional clears
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 3), $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 2);
        end

        // Saturate err_count and wrap txn_count
        cycle(0, 0, 0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), 1, 0);
        end
        repeat (6) cycle(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_response_checker.md
# alu_response_checker

Clocked golden-model checker that sits on the consumer side of the 4-bit ALU. It is fed the same operand and opcode stream that is presented to the ALU and samples the ALU's registered result, carry and zero outputs. Each transaction's expected response is computed and delay-matched to the ALU latency, then compared with the observed response; mismatches are counted, and the first offending transaction is captured. A sticky alarm is raised for Trojan-detection reporting.

## Interface
- LATENCY, 1: cycles from operands applied (in_valid) to ALU outputs valid; legal 1..4
- CNT_W, 8: width of err_count and txn_count
- ALARM_THRESH, 1: err_count value at which alarm asserts; legal 1..2^CNT_W-1

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush of pipeline, counters, capture and alarm
- in_valid  in  1  in_a/in_b/in_op are being applied to the ALU this cycle
- in_a  in  4  operand A
- in_b  in  4  operand B
- in_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- dut_result  in  4  observed ALU result
- dut_carry  in  1  observed ALU carry_out
- dut_zero  in  1  observed ALU zero_flag
- chk_valid  out  1  one-cycle pulse: a comparison completed
- mismatch  out  1  qualified by chk_valid: observed != expected
- exp_result  out  4  expected result of the completed comparison
- exp_carry  out  1  expected carry
- exp_zero  out  1  expected zero flag
- txn_count  out  CNT_W  completed comparisons, wraps
- err_count  out  CNT_W  mismatches, saturates at all-ones
- alarm  out  1  sticky; high while FSM is in ALARM
- first_err_info  out  10  {op,a,b} of first mismatch since reset/clear

## Operation
- Expected model, 5-bit arithmetic: ADD sum=A+B, result=sum[3:0], carry=sum[4]. SUB d=A-B mod 32, result=d[3:0], carry=d[4] (1 iff A<B). AND/OR: result=A&B / A|B, carry=0. zero = (result==0) for all ops.
- Expected tuple {result,carry,zero,op,a,b} plus valid bit enters a LATENCY-deep shift pipeline when in_valid=1. Every cycle it advances; no backpressure; back-to-back in_valid is supported.
- Compare stage: when the pipeline tail is valid, compare the full 6-bit {result,carry,zero} against the dut_* values sampled that cycle. Register outputs.
- FSM: IDLE (reset/clear state, no comparison yet) -> RUN on first chk_valid. RUN -> ALARM when err_count after update >= ALARM_THRESH. Can go IDLE -> ALARM directly if the first comparison trips the threshold. ALARM holds until rst/clear. Checking and counting continue in ALARM.
- first_err_info loads on the first mismatch only (capture flag). Later mismatches do not overwrite it.
- err_count saturates at 2^CNT_W-1 and stays there. txn_count wraps to 0.
- rst or clear: pipeline valid bits zeroed, so in-flight transactions are discarded. Counters, capture flag and first_err_info are set to 0, and FSM goes to IDLE. An in_valid in the same cycle is dropped. rst has priority over clear, with identical effect.

## Timing
- Reset values: chk_valid 0, mismatch 0, exp_result 0, exp_carry 0, exp_zero 0, txn_count 0, err_count 0, alarm 0, first_err_info 0, FSM IDLE.
- in_valid at cycle t -> dut_* sampled at t+LATENCY -> chk_valid, mismatch and exp_* visible at t+LATENCY+1 for one cycle.
- txn_count, err_count and first_err_info update in the same cycle chk_valid/mismatch are visible.
- alarm rises in the same cycle that err_count reaches ALARM_THRESH.
- mismatch and exp_* hold their last value when chk_valid=0. Consumers must qualify with chk_valid.
- Throughput: one comparison per cycle.

## Test plan
- Reset, then ADD A=7,B=9 with DUT returning 0/1/1 at t+1: chk_valid at t+2, mismatch 0, exp 0/1/1, txn_count 1, FSM RUN, alarm 0.
- SUB A=3,B=5 with DUT returning 14/0/0: exp 14/1/0, mismatch 1, err_count 1, alarm 1 (ALARM_THRESH=1), first_err_info={01,3,5}. A second bad transaction leaves first_err_info unchanged.
- Four back-to-back transactions (ADD 1+1, OR 0|0, AND F&A with DUT returning B, SUB 9-9): exactly one mismatch pulse, on the 3rd chk_valid. txn_count 4, err_count 1.
- CNT_W=4: 20 consecutive forced mismatches -> err_count holds at 15, txn_count wraps to 4, alarm stays high.
- clear asserted while one transaction is in flight: no chk_valid follows, all counters 0, alarm 0, FSM IDLE. The next transaction is checked normally.
- LATENCY=2, ALARM_THRESH=3: chk_valid appears at t+3. alarm stays 0 after 2 mismatches and asserts in the cycle of the 3rd.
